// File: rtl/dc_ipu_filter_apply.sv
// rtl/dc_ipu_filter_apply.sv - separable 4x4 RGB weighted-sum filter stage with rounding and clamp
//
// Two-stage pipeline. Stage 1 forms the horizontal weighted sum of each texel row and
// channel. Stage 2 forms the vertical weighted sum, scales it by 2^-2F, clamps it to the
// unsigned channel range and registers the pixel. Throughput is one pixel per clock.
//
// Optional feature macro: DC_IPU_FILTER_APPLY_ROUND_EN
//   defined   : round half up (add 2^(2F-1) before the shift)
//   undefined : floor (plain arithmetic shift)
//
// Ports:
//   clk             clock
//   nreset          synchronous active-low reset
//   clr             synchronous pipeline flush (drops both in-flight items)
//   in_valid        input transfer request
//   in_ready        stage can accept input
//   in_texel_matrix 4x4 packed RGB texels, [row][column], R in MSBs
//   in_weights_x    signed column weights
//   in_weights_y    signed row weights
//   out_valid       output pixel valid
//   out_ready       downstream accepts
//   out_pixel       filtered pixel
module dc_ipu_filter_apply #(
    parameter int RGB_WIDTH          = 24,
    parameter int WEIGHT_WIDTH       = 12,
    parameter int WEIGHT_FRACT_WIDTH = 8
) (
    input  logic                                 clk,
    input  logic                                 nreset,
    input  logic                                 clr,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [0:3][0:3][RGB_WIDTH-1:0]       in_texel_matrix,
    input  logic [0:3][WEIGHT_WIDTH-1:0]         in_weights_x,
    input  logic [0:3][WEIGHT_WIDTH-1:0]         in_weights_y,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [RGB_WIDTH-1:0]                 out_pixel
);

    localparam int CH    = RGB_WIDTH / 3;
    localparam int ROW_W = CH + WEIGHT_WIDTH + 3;
    localparam int ACC_W = ROW_W + WEIGHT_WIDTH + 2;
    localparam int SHIFT = 2 * WEIGHT_FRACT_WIDTH;

`ifdef DC_IPU_FILTER_APPLY_ROUND_EN
    localparam logic [ACC_W-1:0] HALF = ACC_W'(1) << (SHIFT - 1);
`endif

    // Horizontal sum of one row for channel c (0 = R). Texels are zero-extended so the
    // unsigned channel value never reads as negative.
    function automatic logic signed [ROW_W-1:0] h_sum(
        input logic [0:3][RGB_WIDTH-1:0]    row,
        input int                           c,
        input logic [0:3][WEIGHT_WIDTH-1:0] w
    );
        logic signed [ROW_W-1:0] s;
        s = '0;
        for (int j = 0; j < 4; j++) begin
            s = s + ROW_W'($signed({1'b0, row[j][(2-c)*CH +: CH]})) * ROW_W'($signed(w[j]));
        end
        return s;
    endfunction

    function automatic logic signed [ACC_W-1:0] v_sum(
        input logic [0:3][ROW_W-1:0]        rows,
        input logic [0:3][WEIGHT_WIDTH-1:0] w
    );
        logic signed [ACC_W-1:0] s;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            s = s + ACC_W'($signed(rows[i])) * ACC_W'($signed(w[i]));
        end
        return s;
    endfunction

    // Scale by 2^-2F and saturate into [0, 2^CH-1].
    function automatic logic [CH-1:0] scale_clamp(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] r;
`ifdef DC_IPU_FILTER_APPLY_ROUND_EN
        r = (acc + $signed(HALF)) >>> SHIFT;
`else
        r = acc >>> SHIFT;
`endif
        if (r[ACC_W-1]) begin
            return '0;
        end else if (|r[ACC_W-2:CH]) begin
            return '1;
        end else begin
            return r[CH-1:0];
        end
    endfunction

    logic                                s1_valid_q;
    logic                                out_valid_q;
    logic [0:3][ROW_W-1:0]               row_q [3];
    logic [0:3][ROW_W-1:0]               row_d [3];
    logic [0:3][WEIGHT_WIDTH-1:0]        wy_q;
    logic [RGB_WIDTH-1:0]                pixel_q;
    logic [RGB_WIDTH-1:0]                pixel_d;
    logic                                s1_load;
    logic                                s2_load;

    // Stage 2 advances when the output register is empty or being consumed; stage 1
    // advances when it is empty or stage 2 is taking its item.
    assign s2_load  = !out_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load;

    always_comb begin
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 4; i++) begin
                row_d[c][i] = h_sum(in_texel_matrix[i], c, in_weights_x);
            end
        end
    end

    always_comb begin
        pixel_d = '0;
        for (int c = 0; c < 3; c++) begin
            pixel_d[(2-c)*CH +: CH] = scale_clamp(v_sum(row_q[c], wy_q));
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            pixel_q     <= '0;
            wy_q        <= '0;
            for (int c = 0; c < 3; c++) begin
                row_q[c] <= '0;
            end
        end else begin
            if (clr) begin
                s1_valid_q  <= 1'b0;
                out_valid_q <= 1'b0;
            end else begin
                if (s1_load) begin
                    s1_valid_q <= in_valid;
                end
                if (s2_load) begin
                    out_valid_q <= s1_valid_q;
                end
            end
            // Data registers only capture real items so bubbles leave held data intact;
            // a flush leaves them untouched.
            if (!clr && s1_load && in_valid) begin
                wy_q <= in_weights_y;
                for (int c = 0; c < 3; c++) begin
                    row_q[c] <= row_d[c];
                end
            end
            if (!clr && s2_load && s1_valid_q) begin
                pixel_q <= pixel_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_pixel = pixel_q;

endmodule

// File: tb/tb_dc_ipu_filter_apply.sv
// tb/tb_dc_ipu_filter_apply.sv - self-checking bench for dc_ipu_filter_apply
module tb_dc_ipu_filter_apply;

    logic                      clk = 1'b0;
    logic                      nreset = 1'b0;
    logic                      clr = 1'b0;
    logic                      in_valid = 1'b0;
    logic                      in_ready;
    logic [0:3][0:3][23:0]     tex;
    logic [0:3][11:0]          wx;
    logic [0:3][11:0]          wy;
    logic                      out_valid;
    logic                      out_ready = 1'b1;
    logic [23:0]               out_pixel;

    int          checks = 0;
    int          failures = 0;
    int          ndeliv = 0;
    int          d0;
    int          k;
    bit          a;
    bit          saw_full;
    logic [23:0] exp_q [$];
    logic [23:0] rnd_exp;

    always #5 clk = ~clk;

    dc_ipu_filter_apply dut (
        .clk             (clk),
        .nreset          (nreset),
        .clr             (clr),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_texel_matrix (tex),
        .in_weights_x    (wx),
        .in_weights_y    (wy),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pixel       (out_pixel)
    );

    // Reference: per channel, sum_i wy[i] * sum_j texel[i][j] * wx[j], scaled by 2^-16, clamped.
    function automatic logic [23:0] model(
        input logic [0:3][0:3][23:0] t,
        input logic [0:3][11:0]      hx,
        input logic [0:3][11:0]      hy
    );
        logic [23:0] p;
        longint      acc;
        longint      row;
        p = '0;
        for (int c = 0; c < 3; c++) begin
            acc = 0;
            for (int i = 0; i < 4; i++) begin
                row = 0;
                for (int j = 0; j < 4; j++) begin
                    row = row + longint'(t[i][j][(2-c)*8 +: 8]) * longint'($signed(hx[j]));
                end
                acc = acc + row * longint'($signed(hy[i]));
            end
`ifdef DC_IPU_FILTER_APPLY_ROUND_EN
            acc = acc + 64'sd32768;
`endif
            acc = acc >>> 16;
            if (acc < 0) p[(2-c)*8 +: 8] = 8'd0;
            else if (acc > 255) p[(2-c)*8 +: 8] = 8'd255;
            else p[(2-c)*8 +: 8] = acc[7:0];
        end
        return p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) tex[i][j] = 24'($urandom());
            wx[i] = 12'($urandom());
            wy[i] = 12'($urandom());
        end
    endtask

    // One clock: sample at the falling edge, update the scoreboard, return 1ns after the rising edge.
    task automatic tick(output bit accepted);
        @(negedge clk);
        accepted = 1'b0;
        if (!nreset) begin
            exp_q.delete();
        end else begin
            chk("in_ready", 32'(in_ready), (exp_q.size() == 2 && !out_ready) ? 32'd0 : 32'd1);
            if (!in_ready) saw_full = 1'b1;
            if (out_valid) begin
                chk("occupancy", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    chk("pixel", 32'(out_pixel), 32'(exp_q[0]));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        ndeliv++;
                    end
                end
            end
            if (clr) begin
                exp_q.delete();
            end else if (in_valid && in_ready) begin
                exp_q.push_back(model(tex, wx, wy));
                accepted = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Single item through an empty pipe: latency check plus a constant check on masked bits.
    task automatic run_single(input string tag, input logic [23:0] expv, input logic [23:0] mask);
        bit acc_b;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        tick(acc_b);
        chk({tag, "_accept"}, 32'(acc_b), 32'd1);
        in_valid = 1'b0;
        chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
        tick(acc_b);
        chk({tag, "_lat2"}, 32'(out_valid), 32'd1);
        chk({tag, "_value"}, 32'(out_pixel & mask), 32'(expv));
        tick(acc_b);
    endtask

    initial begin
        rand_inputs();
        // Reset
        tick(a);
        tick(a);
        nreset = 1'b1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_pixel", 32'(out_pixel), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        // Bilinear midpoint
        wx = {12'd0, 12'd128, 12'd128, 12'd0};
        wy = wx;
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) tex[i][j] = 24'hFFFFFF;
        tex[1][1] = {8'd100, 8'd10, 8'd0};
        tex[2][1] = {8'd100, 8'd10, 8'd0};
        tex[1][2] = {8'd200, 8'd30, 8'd255};
        tex[2][2] = {8'd200, 8'd30, 8'd255};
        run_single("bilinear", 24'h960000, 24'hFF0000);

        // Identity
        rand_inputs();
        wx = {12'd0, 12'd256, 12'd0, 12'd0};
        wy = wx;
        tex[1][1] = 24'h3C7AE1;
        run_single("identity", 24'h3C7AE1, 24'hFFFFFF);

        // Clamp low / high
        rand_inputs();
        wx = {12'hFE0, 12'd288, 12'd0, 12'd0};
        wy = {12'd0, 12'd256, 12'd0, 12'd0};
        tex[1][0][23:16] = 8'd255;
        tex[1][1][23:16] = 8'd0;
        run_single("clamp_low", 24'h000000, 24'hFF0000);
        tex[1][0][23:16] = 8'd0;
        tex[1][1][23:16] = 8'd255;
        run_single("clamp_high", 24'hFF0000, 24'hFF0000);

        // Rounding of an exact .5 result
        rand_inputs();
        wx = {12'd0, 12'd128, 12'd128, 12'd0};
        wy = wx;
        tex[1][1][23:16] = 8'd100;
        tex[2][1][23:16] = 8'd100;
        tex[1][2][23:16] = 8'd101;
        tex[2][2][23:16] = 8'd101;
`ifdef DC_IPU_FILTER_APPLY_ROUND_EN
        rnd_exp = 24'h650000;
`else
        rnd_exp = 24'h640000;
`endif
        run_single("rounding", rnd_exp, 24'hFF0000);

        // Backpressure: 6 back-to-back items, out_ready low for cycles 3-7
        saw_full = 1'b0;
        d0 = ndeliv;
        k = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 7);
            in_valid  = (k < 6);
            rand_inputs();
            tick(a);
            if (a) k++;
        end
        in_valid = 1'b0;
        chk("bp_accepted", 32'(k), 32'd6);
        chk("bp_delivered", 32'(ndeliv - d0), 32'd6);
        chk("bp_in_ready_low", 32'(saw_full), 32'd1);

        // Flush with two items in flight; offered input in the flush cycle is dropped
        out_ready = 1'b0;
        in_valid  = 1'b1;
        rand_inputs();
        tick(a);
        rand_inputs();
        tick(a);
        chk("clr_full", 32'(out_valid), 32'd1);
        rand_inputs();
        out_ready = 1'b1;
        clr = 1'b1;
        tick(a);
        clr = 1'b0;
        in_valid = 1'b0;
        chk("clr_out_valid", 32'(out_valid), 32'd0);
        tick(a);
        chk("clr_dropped", 32'(out_valid), 32'd0);
        tick(a);
        chk("clr_dropped2", 32'(out_valid), 32'd0);
        rand_inputs();
        run_single("after_clr", model(tex, wx, wy), 24'hFFFFFF);

        // Reset with two items in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        rand_inputs();
        tick(a);
        rand_inputs();
        tick(a);
        nreset = 1'b0;
        in_valid = 1'b0;
        tick(a);
        nreset = 1'b1;
        chk("rst_out_pixel", 32'(out_pixel), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        tick(a);
        tick(a);
        chk("rst_no_output", 32'(out_valid), 32'd0);

        // Random traffic
        for (int n = 0; n < 120; n++) begin
            in_valid  = ($urandom() % 4) != 0;
            out_ready = ($urandom() % 3) != 0;
            rand_inputs();
            tick(a);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 6; n++) tick(a);
        chk("drained", 32'(exp_q.size()), 32'd0);
        chk("final_out_valid", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
